usb_device_fsm: RTL

- Device-side (function) protocol engine; the responder to the host protocol FSM.
- Decodes token packets addressed to this device/endpoint, then:
  - OUT token: receives the following DATA0 packet and answers ACK/NAK.
  - IN token: transmits DATA0 and waits for the host's ACK/NAK.
- Sits between the packet decoder (pkt_in/pkt_received/crc_correct) and the packet encoder (pkt_out/encode/kill/crc_type), with a simple valid/taken data interface to device logic.

---
 rtl/usb_pkg.sv | 54 +++++
 rtl/usb_device_fsm_if.sv | 44 ++++
 rtl/usb_timeout_ctr.sv | 47 ++++
 rtl/usb_device_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared types and constants for the device-side USB protocol engine.
//   pkt_t    : decoded/encoded packet (pid, endp, addr, 64-bit data)
//   PID_*    : packet identifiers understood by the engine
//   CRC_*    : crc_type codes handed to the packet encoder
//   state_e  : protocol FSM states
//   make_hs / make_data0 : build outgoing handshake and data packets
// -----------------------------------------------------------------------------
package usb_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   localparam logic [4:0] CRC_TOKEN = 5'd5;
   localparam logic [4:0] CRC_DATA  = 5'd16;
   localparam logic [4:0] CRC_NONE  = 5'd0;

   typedef struct packed {
      logic [3:0]  pid;
      logic [3:0]  endp;
      logic [6:0]  addr;
      logic [63:0] data;
   } pkt_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_DATA,
      ST_TX_HS,
      ST_TX_DATA,
      ST_RX_HS
   } state_e;

   // Handshakes carry only a PID; the remaining fields are zeroed so stale
   // payload never leaks into the encoder.
   function automatic pkt_t make_hs(input logic [3:0] pid);
      pkt_t p;
      p      = '0;
      p.pid  = pid;
      return p;
   endfunction

   function automatic pkt_t make_data0(input logic [63:0] data);
      pkt_t p;
      p      = '0;
      p.pid  = PID_DATA0;
      p.data = data;
      return p;
   endfunction

endpackage

// File: rtl/usb_device_fsm_if.sv
// -----------------------------------------------------------------------------
// usb_device_fsm_if
// Bundles every non-clock signal of the device protocol engine.
//   Decoder side : pkt_received, crc_correct, pkt_in, decode
//   Encoder side : pkt_sent, pkt_out, encode, kill, crc_type
//   Device side  : tx_data, tx_valid, tx_taken, rx_data, rx_valid,
//                  success, failure
// Modports:
//   master : the surroundings (decoder, encoder, device logic)
//   slave  : the protocol engine itself
// -----------------------------------------------------------------------------
interface usb_device_fsm_if;

   logic          pkt_received;
   logic          crc_correct;
   usb_pkg::pkt_t pkt_in;
   logic          pkt_sent;
   logic [63:0]   tx_data;
   logic          tx_valid;

   usb_pkg::pkt_t pkt_out;
   logic          encode;
   logic          kill;
   logic          decode;
   logic [4:0]    crc_type;
   logic [63:0]   rx_data;
   logic          rx_valid;
   logic          tx_taken;
   logic          success;
   logic          failure;

   modport master (
      output pkt_received, crc_correct, pkt_in, pkt_sent, tx_data, tx_valid,
      input  pkt_out, encode, kill, decode, crc_type, rx_data, rx_valid,
             tx_taken, success, failure
   );

   modport slave (
      input  pkt_received, crc_correct, pkt_in, pkt_sent, tx_data, tx_valid,
      output pkt_out, encode, kill, decode, crc_type, rx_data, rx_valid,
             tx_taken, success, failure
   );

endinterface

// File: rtl/usb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// usb_timeout_ctr
// Idle-cycle counter for the receive states of the protocol engine.
//   clk, rst_b : clock, asynchronous active-low reset
//   clr_all    : clear both the cycle count and the timeout count
//   clr_clk    : clear the cycle count only
//   en         : count this cycle (receiver idle, no limit reached)
//   timeout    : combinational strobe, high on the counting cycle where the
//                cycle count equals TIMEOUT (one period = TIMEOUT+1 cycles)
//   tmo_cnt    : number of timeouts seen, saturating at all-ones
// -----------------------------------------------------------------------------
module usb_timeout_ctr #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       clr_all,
   input  logic       clr_clk,
   input  logic       en,
   output logic       timeout,
   output logic [3:0] tmo_cnt
);

   logic [7:0] clk_count;

   assign timeout = en && (clk_count == TIMEOUT);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         clk_count <= '0;
         tmo_cnt   <= '0;
      end else if (clr_all) begin
         clk_count <= '0;
         tmo_cnt   <= '0;
      end else if (clr_clk) begin
         clk_count <= '0;
      end else if (en) begin
         if (timeout) begin
            clk_count <= '0;
            if (tmo_cnt != 4'hF) tmo_cnt <= tmo_cnt + 4'd1;
         end else begin
            clk_count <= clk_count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/usb_device_fsm.sv
// -----------------------------------------------------------------------------
// usb_device_fsm
// Device-side USB protocol engine. Accepts OUT/IN tokens addressed to
// DEV_ADDR/DEV_ENDP; for OUT it receives one DATA0 packet and answers
// ACK (good CRC) or NAK (bad CRC); for IN it sends DATA0 (or NAK when the
// device has nothing to send) and waits for the host handshake, resending
// on NAK, corruption or timeout. Gives up with a failure pulse once the
// retry or timeout count reaches MAX_RETRY.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : usb_device_fsm_if.slave (decoder, encoder, device data)
// All outputs are registered.
// -----------------------------------------------------------------------------
module usb_device_fsm
   import usb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = 7'd5,
   parameter logic [3:0] DEV_ENDP  = 4'd4,
   parameter logic [7:0] TIMEOUT   = 8'd255,
   parameter logic [3:0] MAX_RETRY = 4'd8
) (
   input  logic              clk,
   input  logic              rst_b,
   usb_device_fsm_if.slave   bus
);

   state_e     state;
   state_e     ret_state;   // where TxHs goes once the handshake is out
   logic       ack_path;    // the pending handshake is the final ACK
   logic [3:0] retry_cnt;
   logic [3:0] tmo_cnt;
   logic       timeout;

   logic       in_rx;
   logic       limit_hit;
   logic       tok_match;
   logic       good_pkt;
   logic       bad_pkt;
   logic       cnt_en;
   logic       clr_all;
   logic       clr_clk;

   assign in_rx     = (state == ST_RX_DATA) || (state == ST_RX_HS);
   assign limit_hit = (retry_cnt == MAX_RETRY) || (tmo_cnt == MAX_RETRY);
   assign good_pkt  = bus.pkt_received && bus.crc_correct;
   assign bad_pkt   = bus.pkt_received && !bus.crc_correct;
   assign tok_match = good_pkt && (bus.pkt_in.addr == DEV_ADDR)
                               && (bus.pkt_in.endp == DEV_ENDP);

   // Any received packet suspends the idle count for that cycle, so a packet
   // landing on the timeout cycle is handled and the timeout is not taken.
   assign cnt_en  = in_rx && !limit_hit && !bus.pkt_received;
   assign clr_all = (state == ST_IDLE);
   // Transmit states hold the cycle count at zero so every receive window
   // starts from a fresh count.
   assign clr_clk = (state == ST_TX_HS) || (state == ST_TX_DATA);

   usb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .rst_b   (rst_b),
      .clr_all (clr_all),
      .clr_clk (clr_clk),
      .en      (cnt_en),
      .timeout (timeout),
      .tmo_cnt (tmo_cnt)
   );

   // NOTE: all state and outputs live in one clocked block and use
   // non-blocking assignments, so every read sees the pre-edge value.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state         <= ST_IDLE;
         ret_state     <= ST_IDLE;
         ack_path      <= 1'b0;
         retry_cnt     <= '0;
         bus.pkt_out   <= '0;
         bus.crc_type  <= CRC_NONE;
         bus.rx_data   <= '0;
         bus.encode    <= 1'b0;
         bus.kill      <= 1'b0;
         bus.decode    <= 1'b0;
         bus.rx_valid  <= 1'b0;
         bus.tx_taken  <= 1'b0;
         bus.success   <= 1'b0;
         bus.failure   <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle; a branch that wants a pulse
         // overrides the default for exactly one cycle.
         bus.encode   <= 1'b0;
         bus.kill     <= 1'b0;
         bus.decode   <= 1'b0;
         bus.rx_valid <= 1'b0;
         bus.tx_taken <= 1'b0;
         bus.success  <= 1'b0;
         bus.failure  <= 1'b0;

         case (state)
            ST_IDLE: begin
               retry_cnt  <= '0;
               bus.decode <= 1'b1;
               if (tok_match && bus.pkt_in.pid == PID_OUT) begin
                  bus.decode <= 1'b0;
                  state      <= ST_RX_DATA;
               end else if (tok_match && bus.pkt_in.pid == PID_IN) begin
                  bus.decode <= 1'b0;
                  bus.encode <= 1'b1;
                  bus.kill   <= 1'b1;
                  if (bus.tx_valid) begin
                     bus.pkt_out  <= make_data0(bus.tx_data);
                     bus.crc_type <= CRC_DATA;
                     state        <= ST_TX_DATA;
                  end else begin
                     bus.pkt_out  <= make_hs(PID_NAK);
                     bus.crc_type <= CRC_NONE;
                     ret_state    <= ST_IDLE;
                     ack_path     <= 1'b0;
                     state        <= ST_TX_HS;
                  end
               end
            end

            ST_RX_DATA: begin
               if (limit_hit) begin
                  bus.failure <= 1'b1;
                  state       <= ST_IDLE;
               end else if (bad_pkt) begin
                  retry_cnt    <= retry_cnt + 4'd1;
                  bus.pkt_out  <= make_hs(PID_NAK);
                  bus.crc_type <= CRC_NONE;
                  bus.encode   <= 1'b1;
                  bus.kill     <= 1'b1;
                  ret_state    <= ST_RX_DATA;
                  ack_path     <= 1'b0;
                  state        <= ST_TX_HS;
               end else if (good_pkt && bus.pkt_in.pid == PID_DATA0) begin
                  bus.rx_data  <= bus.pkt_in.data;
                  bus.rx_valid <= 1'b1;
                  bus.pkt_out  <= make_hs(PID_ACK);
                  bus.crc_type <= CRC_NONE;
                  bus.encode   <= 1'b1;
                  bus.kill     <= 1'b1;
                  ret_state    <= ST_IDLE;
                  ack_path     <= 1'b1;
                  state        <= ST_TX_HS;
               end
               // Other packets are ignored; a timeout only bumps tmo_cnt in
               // the counter and the host is expected to retransmit.
            end

            ST_TX_HS: begin
               if (bus.pkt_sent) begin
                  state       <= ret_state;
                  bus.decode  <= (ret_state == ST_RX_DATA);
                  bus.success <= ack_path;
               end
            end

            ST_TX_DATA: begin
               if (bus.pkt_sent) begin
                  bus.decode <= 1'b1;
                  state      <= ST_RX_HS;
               end
            end

            ST_RX_HS: begin
               if (limit_hit) begin
                  bus.failure <= 1'b1;
                  state       <= ST_IDLE;
               end else if (good_pkt && bus.pkt_in.pid == PID_ACK) begin
                  bus.tx_taken <= 1'b1;
                  bus.success  <= 1'b1;
                  state        <= ST_IDLE;
               end else if (bad_pkt || (good_pkt && bus.pkt_in.pid == PID_NAK)) begin
                  // pkt_out still holds the DATA0 packet, so a resend only
                  // needs a new encode pulse.
                  retry_cnt    <= retry_cnt + 4'd1;
                  bus.crc_type <= CRC_DATA;
                  bus.encode   <= 1'b1;
                  bus.kill     <= 1'b1;
                  state        <= ST_TX_DATA;
               end else if (timeout) begin
                  bus.crc_type <= CRC_DATA;
                  bus.encode   <= 1'b1;
                  bus.kill     <= 1'b1;
                  state        <= ST_TX_DATA;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
